// File: rtl/reg_bank_ctrl.sv
// Register bank behind the SPI transaction layer. It holds RW config registers,
// W1C status registers, an interrupt enable register and drives a registered irq.
//
// state | meaning
// IDLE  | waiting for req && ena; the transaction executes on the accepting edge
// RESP  | ack/err/rdata are high for this one cycle; req is not sampled
module reg_bank_ctrl #(
    parameter int ADDR_W = 4,
    parameter int REG_W  = 8,
    parameter int NUM_RW = 4,
    parameter int NUM_ST = 2
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     ena,
    input  logic                     req,
    input  logic                     wr_rdn,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [REG_W-1:0]         wdata,
    output logic [REG_W-1:0]         rdata,
    output logic                     ack,
    output logic                     err,
    output logic [NUM_RW*REG_W-1:0]  cfg_out,
    input  logic [NUM_ST*REG_W-1:0]  sts_set,
    output logic                     irq
);

    localparam int IDX_EN = NUM_RW + NUM_ST;

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic [REG_W-1:0]  cfg [NUM_RW];
    logic [REG_W-1:0]  sts [NUM_ST];
    logic [REG_W-1:0]  sts_clr [NUM_ST];
    logic [NUM_ST-1:0] irq_en;
    logic [NUM_ST-1:0] sts_any;
    logic [NUM_RW-1:0] hit_cfg;
    logic [NUM_ST-1:0] hit_sts;
    logic              hit_en;
    logic              addr_ok;
    logic              do_wr;
    logic [REG_W-1:0]  rd_val;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (req && ena) begin
                accept    = 1'b1;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hit_cfg = '0;
        hit_sts = '0;
        hit_en  = 1'b0;
        rd_val  = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (addr == ADDR_W'(i)) begin
                hit_cfg[i] = 1'b1;
                rd_val     = cfg[i];
            end
        end
        for (int j = 0; j < NUM_ST; j++) begin
            if (addr == ADDR_W'(NUM_RW + j)) begin
                hit_sts[j] = 1'b1;
                rd_val     = sts[j];
            end
        end
        if (addr == ADDR_W'(IDX_EN)) begin
            hit_en = 1'b1;
            rd_val = REG_W'(irq_en);
        end
        addr_ok = (|hit_cfg) | (|hit_sts) | hit_en;
        do_wr   = accept & wr_rdn;
        for (int j = 0; j < NUM_ST; j++) begin
            sts_clr[j] = (do_wr && hit_sts[j]) ? wdata : '0;
            sts_any[j] = |sts[j];
        end
    end

    // Set pulses are ORed in after the clear mask, so a same-edge set wins.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_RW; i++) cfg[i] <= '0;
            for (int j = 0; j < NUM_ST; j++) sts[j] <= '0;
            irq_en <= '0;
            ack    <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
            irq    <= 1'b0;
        end else begin
            ack   <= accept;
            err   <= accept & ~addr_ok;
            rdata <= (accept && !wr_rdn && addr_ok) ? rd_val : '0;
            for (int i = 0; i < NUM_RW; i++) begin
                if (do_wr && hit_cfg[i]) cfg[i] <= wdata;
            end
            for (int j = 0; j < NUM_ST; j++) begin
                sts[j] <= (sts[j] & ~sts_clr[j]) | sts_set[j*REG_W +: REG_W];
            end
            if (do_wr && hit_en) irq_en <= wdata[NUM_ST-1:0];
            irq <= |(sts_any & irq_en);
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_cfg_out
        assign cfg_out[g*REG_W +: REG_W] = cfg[g];
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl with default parameters; inputs change and
// outputs are sampled on the falling clock edge.
module tb_reg_bank_ctrl;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic        req;
    logic        wr_rdn;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        err;
    logic [31:0] cfg_out;
    logic [15:0] sts_set;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    logic       t_ack, t_err;
    logic [7:0] t_rdata;

    reg_bank_ctrl #(.ADDR_W(4), .REG_W(8), .NUM_RW(4), .NUM_ST(2)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .req(req), .wr_rdn(wr_rdn),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err),
        .cfg_out(cfg_out), .sts_set(sts_set), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction, with optional status set pulse on the accepting edge.
    // Returns at the falling edge inside the response cycle.
    task automatic txn(input logic wr, input logic [3:0] a, input logic [7:0] d,
                       input logic [15:0] s);
        @(negedge clk);
        req = 1'b1; wr_rdn = wr; addr = a; wdata = d; sts_set = s;
        @(negedge clk);
        req = 1'b0; sts_set = '0;
        t_ack = ack; t_err = err; t_rdata = rdata;
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; req = 1'b0; wr_rdn = 1'b0;
        addr = '0; wdata = '0; sts_set = '0;
        #12;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_cfg_out", cfg_out, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk); rstb = 1'b1;

        // RW config
        txn(1'b1, 4'd2, 8'hA5, 16'h0);
        chk("wr_cfg2_ack", 32'(t_ack), 32'd1);
        chk("wr_cfg2_err", 32'(t_err), 32'd0);
        chk("wr_cfg2_rdata", 32'(t_rdata), 32'd0);
        chk("wr_cfg2_cfg_out", cfg_out, 32'h00A5_0000);
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack), 32'd0);
        txn(1'b0, 4'd2, 8'h00, 16'h0);
        chk("rd_cfg2_ack", 32'(t_ack), 32'd1);
        chk("rd_cfg2_rdata", 32'(t_rdata), 32'hA5);
        @(negedge clk);
        chk("rdata_zero_no_ack", 32'(rdata), 32'd0);

        // W1C status
        sts_set = 16'h0081;
        @(negedge clk); sts_set = '0;
        txn(1'b0, 4'd4, 8'h00, 16'h0);
        chk("rd_sts0_set", 32'(t_rdata), 32'h81);
        txn(1'b1, 4'd4, 8'h01, 16'h0);
        txn(1'b0, 4'd4, 8'h00, 16'h0);
        chk("rd_sts0_w1c", 32'(t_rdata), 32'h80);
        txn(1'b1, 4'd4, 8'h01, 16'h0001);
        txn(1'b0, 4'd4, 8'h00, 16'h0);
        chk("set_wins_over_clr", 32'(t_rdata), 32'h81);

        // IRQ enable: upper bits read 0
        txn(1'b1, 4'd6, 8'hFF, 16'h0);
        txn(1'b0, 4'd6, 8'h00, 16'h0);
        chk("rd_irq_en_mask", 32'(t_rdata), 32'h03);
        txn(1'b1, 4'd6, 8'h02, 16'h0);
        repeat (3) @(negedge clk);
        chk("irq_off_en2", 32'(irq), 32'd0);
        sts_set = 16'h0800;
        @(negedge clk);
        sts_set = '0;
        chk("irq_lag_set", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_on", 32'(irq), 32'd1);
        txn(1'b1, 4'd5, 8'h08, 16'h0);
        chk("irq_lag_clr", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_off_after_clr", 32'(irq), 32'd0);

        // Invalid addresses
        txn(1'b0, 4'd7, 8'h00, 16'h0);
        chk("rd7_ack", 32'(t_ack), 32'd1);
        chk("rd7_err", 32'(t_err), 32'd1);
        chk("rd7_rdata", 32'(t_rdata), 32'd0);
        txn(1'b1, 4'd15, 8'hFF, 16'h0);
        chk("wr15_ack", 32'(t_ack), 32'd1);
        chk("wr15_err", 32'(t_err), 32'd1);
        chk("wr15_rdata", 32'(t_rdata), 32'd0);
        chk("wr15_cfg_out", cfg_out, 32'h00A5_0000);
        txn(1'b0, 4'd6, 8'h00, 16'h0);
        chk("wr15_irq_en", 32'(t_rdata), 32'h02);
        chk("valid_err", 32'(t_err), 32'd0);
        txn(1'b0, 4'd4, 8'h00, 16'h0);
        chk("wr15_sts0", 32'(t_rdata), 32'h81);

        // Handshake: req held 5 edges
        @(negedge clk);
        req = 1'b1; wr_rdn = 1'b0; addr = 4'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold_ack_%0d", k), 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        req = 1'b0;
        @(negedge clk);
        ena = 1'b0; req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ena0_ack_%0d", k), 32'(ack), 32'd0);
        end
        req = 1'b0; ena = 1'b1;

        // Reset mid-response
        txn(1'b1, 4'd6, 8'h03, 16'h0);
        repeat (2) @(negedge clk);
        chk("irq_pre_reset", 32'(irq), 32'd1);
        @(negedge clk);
        req = 1'b1; wr_rdn = 1'b0; addr = 4'd7;
        @(posedge clk);
        #2;
        req = 1'b0;
        chk("pre_rst_err", 32'(err), 32'd1);
        rstb = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_rdata", 32'(rdata), 32'd0);
        chk("mid_rst_cfg_out", cfg_out, 32'd0);
        @(negedge clk); rstb = 1'b1;
        for (int a = 0; a < 7; a++) begin
            txn(1'b0, 4'(a), 8'h00, 16'h0);
            chk($sformatf("post_rst_rd_%0d", a), {23'd0, t_ack, t_rdata}, 32'h100);
        end
        repeat (2) @(negedge clk);
        chk("post_rst_irq", 32'(irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
